// File: rtl/bubblesort_engine_if.sv
// Host-side bundle for the sort engine: load stream, drain stream, mode/abort controls and status.
interface bubblesort_engine_if #(
  parameter int WIDTH  = 8,
  parameter int CWIDTH = 8
);
  logic              Descend;
  logic              Abort;
  logic              InValid;
  logic              InReady;
  logic [WIDTH-1:0]  InData;
  logic              OutValid;
  logic              OutReady;
  logic [WIDTH-1:0]  OutData;
  logic              Busy;
  logic              Done;
  logic [CWIDTH-1:0] PassCount;

  modport master (
    output Descend, Abort, InValid, InData, OutReady,
    input  InReady, OutValid, OutData, Busy, Done, PassCount
  );

  modport slave (
    input  Descend, Abort, InValid, InData, OutReady,
    output InReady, OutValid, OutData, Busy, Done, PassCount
  );
endinterface

// File: rtl/bubblesort_engine.sv
// Odd-even transposition sorter: serial load, one compare/swap pass per clock, serial drain from element 0.
module bubblesort_engine #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int IDXW       = 3,
  parameter int CWIDTH     = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                Clk,
  input  logic                Reset_n,
  bubblesort_engine_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SORT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(DEPTH - 1);
  localparam logic [CWIDTH-1:0] MAX_PASS = CWIDTH'(DEPTH);

  logic [1:0]        state;
  logic [WIDTH-1:0]  elem   [DEPTH];
  logic [WIDTH-1:0]  sorted [DEPTH];
  logic [IDXW-1:0]   idx;
  logic [CWIDTH-1:0] pass_cnt;
  logic [CWIDTH-1:0] pass_next;
  logic              desc;
  logic              prev_clean;
  logic              swapped;
  logic              done;
  logic              in_fire;
  logic              sort_exit;

  assign bus.InReady   = (state == S_IDLE) || (state == S_LOAD);
  assign bus.OutValid  = (state == S_DRAIN);
  assign bus.OutData   = elem[0];
  assign bus.Busy      = (state != S_IDLE);
  assign bus.Done      = done;
  assign bus.PassCount = pass_cnt;

  assign in_fire   = bus.InValid && bus.InReady;
  assign pass_next = pass_cnt + CWIDTH'(1);

  // Pass parity follows PassCount: even passes pair (0,1),(2,3)..., odd passes pair (1,2),(3,4)...
  always_comb begin
    sorted  = elem;
    swapped = 1'b0;
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      if (i[0] == pass_cnt[0]) begin
        if (desc ? (elem[i] < elem[i+1]) : (elem[i] > elem[i+1])) begin
          sorted[i]   = elem[i+1];
          sorted[i+1] = elem[i];
          swapped     = 1'b1;
        end
      end
    end
  end

  // prev_clean is cleared at load start, so early exit can never fire before the second pass.
  assign sort_exit = (pass_next == MAX_PASS) ||
                     ((EARLY_EXIT != 0) && !swapped && prev_clean);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      pass_cnt   <= '0;
      desc       <= 1'b0;
      prev_clean <= 1'b0;
      done       <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) elem[i] <= '0;
    end else begin
      done <= 1'b0;
      if (bus.Abort) begin
        state      <= S_IDLE;
        idx        <= '0;
        prev_clean <= 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) elem[i] <= '0;
      end else begin
        case (state)
          S_IDLE, S_LOAD: begin
            if (in_fire) begin
              elem[idx] <= bus.InData;
              if (state == S_IDLE) begin
                desc       <= bus.Descend;
                pass_cnt   <= '0;
                prev_clean <= 1'b0;
              end
              if (idx == LAST_IDX) begin
                idx   <= '0;
                state <= S_SORT;
              end else begin
                idx   <= idx + IDXW'(1);
                state <= S_LOAD;
              end
            end
          end
          S_SORT: begin
            elem       <= sorted;
            pass_cnt   <= pass_next;
            prev_clean <= !swapped;
            if (sort_exit) state <= S_DRAIN;
          end
          S_DRAIN: begin
            if (bus.OutReady) begin
              for (int unsigned i = 0; i < DEPTH - 1; i++) elem[i] <= elem[i+1];
              elem[DEPTH-1] <= '0;
              if (idx == LAST_IDX) begin
                idx   <= '0;
                state <= S_IDLE;
                done  <= 1'b1;
              end else begin
                idx <= idx + IDXW'(1);
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bubblesort_engine.sv
// Randomized bench for bubblesort_engine against a queue-sort plus pass-count reference model.
module tb_bubblesort_engine;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bubblesort_engine_if #(.WIDTH(8), .CWIDTH(8)) bus ();

  bubblesort_engine #(
    .WIDTH(8), .DEPTH(8), .IDXW(3), .CWIDTH(8), .EARLY_EXIT(1)
  ) dut (
    .Clk(clk),
    .Reset_n(rst_n),
    .bus(bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_passed = 0;
  logic [7:0]  ld [8];
  int          exp_q[$];
  int          exp_passes;
  int          latency;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: sorted order from a queue sort; pass count from running transposition passes on a copy.
  task automatic build_model(input bit desc);
    logic [7:0] a [8];
    logic [7:0] t;
    bit sw, prev_ns, stop;
    int p;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      a[i] = ld[i];
      exp_q.push_back(int'(ld[i]));
    end
    if (desc) exp_q.rsort(); else exp_q.sort();
    p = 0; prev_ns = 0; stop = 0;
    while (!stop) begin
      sw = 0;
      for (int i = p % 2; i + 1 < 8; i += 2) begin
        if (desc ? (a[i] < a[i+1]) : (a[i] > a[i+1])) begin
          t = a[i]; a[i] = a[i+1]; a[i+1] = t; sw = 1;
        end
      end
      p++;
      if (p == 8 || (!sw && prev_ns)) stop = 1;
      prev_ns = !sw;
    end
    exp_passes = p;
  endtask

  // Ends on the negedge after the final load edge, with InValid dropped.
  task automatic load_words(input bit desc, input int max_gap);
    int g;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (max_gap > 0) begin
        g = int'($urandom_range(max_gap, 0));
        bus.InValid = 1'b0;
        repeat (g) @(negedge clk);
      end
      check("in_ready", bus.InReady, 1);
      bus.InValid = 1'b1;
      bus.InData  = ld[k];
      bus.Descend = (k == 0) ? desc : 1'($urandom_range(1, 0));
    end
    @(negedge clk);
    bus.InValid = 1'b0;
  endtask

  task automatic wait_out();
    latency = 0;
    while (!bus.OutValid && latency < 40) begin
      check("sort_in_ready_low", bus.InReady, 0);
      @(negedge clk);
      latency++;
    end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1 repeating, 2: random ready.
  task automatic drain_words(input int mode, input int stop_after);
    int j, cyc;
    bit rdy, holding;
    logic [7:0] held;
    j = 0; cyc = 0; holding = 0; held = '0;
    while (j < stop_after && cyc < 300) begin
      if (holding) check("hold_data", bus.OutData, held);
      check("done_low", bus.Done, 0);
      check("out_valid", bus.OutValid, 1);
      rdy = (mode == 0) ? 1'b1 :
            (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) :
                          1'($urandom_range(1, 0));
      bus.OutReady = rdy;
      if (rdy) begin
        check($sformatf("out_data[%0d]", j), bus.OutData, exp_q[j]);
        j++;
        holding = 0;
      end else begin
        holding = 1;
        held    = bus.OutData;
      end
      @(negedge clk);
      cyc++;
    end
    bus.OutReady = 1'b0;
    if (j < stop_after) check("drain_timeout", j, stop_after);
  endtask

  task automatic finish_drain();
    check("done_pulse", bus.Done, 1);
    check("out_valid_after", bus.OutValid, 0);
    check("busy_after", bus.Busy, 0);
    check("in_ready_after", bus.InReady, 1);
    check("pass_count_hold", bus.PassCount, exp_passes);
    @(negedge clk);
    check("done_one_cycle", bus.Done, 0);
  endtask

  task automatic run_case(input bit desc, input int gap, input int mode);
    build_model(desc);
    load_words(desc, gap);
    wait_out();
    check("latency", latency, exp_passes);
    check("pass_count", bus.PassCount, exp_passes);
    drain_words(mode, 8);
    finish_drain();
  endtask

  task automatic load_scn1();
    ld = '{8'd7, 8'd3, 8'd9, 8'd1, 8'd9, 8'd0, 8'd255, 8'd4};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks so far %0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    bus.Descend = 0; bus.Abort = 0; bus.InValid = 0; bus.InData = '0; bus.OutReady = 0;

    // reset values
    @(negedge clk);
    check("rst_in_ready", bus.InReady, 1);
    check("rst_out_valid", bus.OutValid, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.Done, 0);
    check("rst_out_data", bus.OutData, 0);
    check("rst_pass_count", bus.PassCount, 0);
    rst_n = 1'b1;

    // scenario 1
    load_scn1();
    run_case(0, 0, 0);
    check("scn1_pc_range", (exp_passes >= 2 && exp_passes <= 8), 1);

    // scenario 2: already ascending
    for (int i = 0; i < 8; i++) ld[i] = 8'(i + 1);
    run_case(0, 0, 0);
    check("presorted_passes", bus.PassCount, 2);

    // scenario 3: reversed, both modes
    for (int i = 0; i < 8; i++) ld[i] = 8'(8 - i);
    run_case(0, 0, 0);
    check("reverse_asc_passes", bus.PassCount, 8);
    run_case(1, 0, 0);
    check("reverse_desc_passes", bus.PassCount, 2);

    // scenario 4: stalled drain
    for (int i = 0; i < 8; i++) ld[i] = 8'($urandom_range(255, 0));
    run_case(0, 0, 1);

    // scenario 5a: abort during SORT at PassCount 3
    for (int i = 0; i < 8; i++) ld[i] = 8'(8 - i);
    load_words(0, 0);
    cyc = 0;
    while (bus.PassCount != 8'd3 && cyc < 20) begin @(negedge clk); cyc++; end
    check("abort_reach_pc3", bus.PassCount, 3);
    bus.Abort = 1'b1; bus.InValid = 1'b1; bus.InData = 8'hAA;
    @(negedge clk);
    bus.Abort = 1'b0; bus.InValid = 1'b0;
    check("abort_busy", bus.Busy, 0);
    check("abort_in_ready", bus.InReady, 1);
    check("abort_out_valid", bus.OutValid, 0);
    check("abort_pc_kept", bus.PassCount, 3);
    check("abort_out_data", bus.OutData, 0);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_done", bus.Done, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) ld[i] = 8'd5;
    run_case(0, 0, 0);
    check("all_equal_passes", bus.PassCount, 2);

    // scenario 5b: abort mid-LOAD with a word offered in the abort cycle
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.InValid = 1'b1; bus.InData = 8'(200 + k); bus.Descend = 1'b1;
    end
    @(negedge clk);
    bus.Abort = 1'b1; bus.InData = 8'd99;
    @(negedge clk);
    bus.Abort = 1'b0; bus.InValid = 1'b0;
    check("abort_load_busy", bus.Busy, 0);
    for (int i = 0; i < 8; i++) ld[i] = 8'($urandom_range(255, 0));
    run_case(0, 0, 0);

    // scenario 6: reset during drain after 3 outputs
    load_scn1();
    build_model(0);
    load_words(0, 0);
    wait_out();
    drain_words(0, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.OutValid, 0);
    check("mid_rst_busy", bus.Busy, 0);
    check("mid_rst_pass_count", bus.PassCount, 0);
    check("mid_rst_done", bus.Done, 0);
    check("mid_rst_out_data", bus.OutData, 0);
    @(negedge clk);
    check("mid_rst_no_done", bus.Done, 0);
    rst_n = 1'b1;
    load_scn1();
    run_case(0, 0, 0);

    // randomized runs with duplicates, load gaps and random backpressure
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) ld[i] = 8'($urandom_range(15, 0));
      run_case(1'($urandom_range(1, 0)), 2, 2);
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
